// File: rtl/key_sw_io.sv
// key_sw_io: memory-mapped push-button / slide-switch input controller.
// Raw KEY/SW pins are double-flop synchronized, debounced per bit, and
// exposed as data registers (KDATA/SDATA) plus control/status registers
// (KCTRL/SCTRL) carrying a ready flag (bit 0) and an overrun flag (bit 2).
// Bus handshake: there is no stall; rData/hit are combinational from addr
// in the same cycle, and a cycle with rdEn=1 (load) or wrEn=1 (store)
// commits its side effects on the following rising clock edge.
module key_sw_io #(
  parameter int                DBITS           = 32,
  parameter int                DEBOUNCE_CYCLES = 4,
  parameter int                CNT_BITS        = 20,
  parameter logic [DBITS-1:0]  ADDR_KDATA      = 32'hF0000010,
  parameter logic [DBITS-1:0]  ADDR_SDATA      = 32'hF0000014,
  parameter logic [DBITS-1:0]  ADDR_KCTRL      = 32'hF0000110,
  parameter logic [DBITS-1:0]  ADDR_SCTRL      = 32'hF0000114
) (
  input  logic             clk,
  input  logic             reset,
  input  logic [3:0]       KEY,
  input  logic [9:0]       SW,
  input  logic [DBITS-1:0] addr,
  input  logic             rdEn,
  input  logic             wrEn,
  input  logic [DBITS-1:0] wData,
  output logic [DBITS-1:0] rData,
  output logic             hit
);

  // Bits [3:0] are keys (idle high), bits [13:4] are switches (idle low).
  localparam int                NB       = 14;
  localparam logic [NB-1:0]     IDLE_VAL = 14'h000F;
  localparam logic [CNT_BITS-1:0] CNT_MAX = CNT_BITS'(DEBOUNCE_CYCLES - 1);

  logic [NB-1:0]       r_sync1;
  logic [NB-1:0]       r_sync2;
  logic [NB-1:0]       r_stable;
  logic [CNT_BITS-1:0] r_cnt [NB];
  logic [NB-1:0]       w_accept;

  logic r_k_rdy, r_k_ovr, r_s_rdy, r_s_ovr;
  logic w_key_chg, w_sw_chg;
  logic w_rd_kdata, w_rd_sdata, w_clr_kovr, w_clr_sovr;
  logic w_unused_wdata;

  // Two-flop synchronizer; reset to the idle level of each pin.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      r_sync1 <= IDLE_VAL;
      r_sync2 <= IDLE_VAL;
    end else begin
      r_sync1 <= {SW, KEY};
      r_sync2 <= r_sync1;
    end
  end

  // A bit is accepted on the DEBOUNCE_CYCLES-th consecutive mismatching cycle.
  always_comb begin
    w_accept = '0;
    for (int i = 0; i < NB; i++) begin
      w_accept[i] = (r_sync2[i] != r_stable[i]) && (r_cnt[i] == CNT_MAX);
    end
  end

  // Per-bit debounce counter and accepted (stable) value.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      r_stable <= IDLE_VAL;
      for (int i = 0; i < NB; i++) r_cnt[i] <= '0;
    end else begin
      for (int i = 0; i < NB; i++) begin
        if (r_sync2[i] == r_stable[i]) begin
          r_cnt[i] <= '0;
        end else if (w_accept[i]) begin
          r_stable[i] <= r_sync2[i];
          r_cnt[i]    <= '0;
        end else begin
          r_cnt[i] <= r_cnt[i] + 1'b1;
        end
      end
    end
  end

  assign w_key_chg  = |w_accept[3:0];
  assign w_sw_chg   = |w_accept[13:4];
  assign w_rd_kdata = rdEn && (addr == ADDR_KDATA);
  assign w_rd_sdata = rdEn && (addr == ADDR_SDATA);
  assign w_clr_kovr = wrEn && (addr == ADDR_KCTRL) && !wData[2];
  assign w_clr_sovr = wrEn && (addr == ADDR_SCTRL) && !wData[2];

  // Only wData[2] has meaning on this device.
  assign w_unused_wdata = ^{wData[DBITS-1:3], wData[1:0]};

  // Ready/overrun flags: a data read consumes the old value, so a change
  // coinciding with it is not an overrun; overrun set beats a clear.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      r_k_rdy <= 1'b0;
      r_k_ovr <= 1'b0;
      r_s_rdy <= 1'b0;
      r_s_ovr <= 1'b0;
    end else begin
      if (w_key_chg)       r_k_rdy <= 1'b1;
      else if (w_rd_kdata) r_k_rdy <= 1'b0;

      if (w_key_chg && r_k_rdy && !w_rd_kdata) r_k_ovr <= 1'b1;
      else if (w_clr_kovr)                     r_k_ovr <= 1'b0;

      if (w_sw_chg)        r_s_rdy <= 1'b1;
      else if (w_rd_sdata) r_s_rdy <= 1'b0;

      if (w_sw_chg && r_s_rdy && !w_rd_sdata) r_s_ovr <= 1'b1;
      else if (w_clr_sovr)                    r_s_ovr <= 1'b0;
    end
  end

  // Combinational read mux and address decode.
  always_comb begin
    rData = '0;
    hit   = 1'b0;
    if (addr == ADDR_KDATA) begin
      hit   = 1'b1;
      rData = {{(DBITS-4){1'b0}}, ~r_stable[3:0]};
    end else if (addr == ADDR_SDATA) begin
      hit   = 1'b1;
      rData = {{(DBITS-10){1'b0}}, r_stable[13:4]};
    end else if (addr == ADDR_KCTRL) begin
      hit   = 1'b1;
      rData = {{(DBITS-3){1'b0}}, r_k_ovr, 1'b0, r_k_rdy};
    end else if (addr == ADDR_SCTRL) begin
      hit   = 1'b1;
      rData = {{(DBITS-3){1'b0}}, r_s_ovr, 1'b0, r_s_rdy};
    end
  end

endmodule
